// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small instruction buffer with push/pop/flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [63:0]                    push_data_i,
    input  logic                           pop_i,
    output logic [63:0]                    head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = $clog2(DEPTH + 1);

    fetch_entry_t               mem_q [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [COUNT_W-1:0]         count_q;
    logic                       do_push;
    logic                       do_pop;

    // A pop frees a slot in the same cycle, so a full buffer may still accept.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!n_rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
            end
            if (do_pop) begin
                rd_ptr_q <= PTR_W'(rd_ptr_q + 1'b1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == COUNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM feeding a 2-entry buffer toward decode
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_t                  state_q;
    fetch_state_t                  state_d;
    logic [31:0]                   pc_q;
    logic [31:0]                   pc_d;
    logic [31:0]                   req_addr_q;
    logic                          issue;
    logic                          push;
    logic                          pop;
    logic                          fifo_full;
    logic [$clog2(DEPTH+1)-1:0]    fifo_count;
    fetch_entry_t                  push_entry;
    fetch_entry_t                  head_entry;

    assign issue = (state_q == FETCH) && !fifo_full;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (issue && !imem_ack) begin
                    state_d = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Outside FETCH the address comes from the latched request, so a redirect
    // can move pc while the old request is still held on the bus.
    always_comb begin
        imem_req  = n_rst && ((state_q != FETCH) || !fifo_full);
        imem_addr = (state_q == FETCH) ? pc_q : req_addr_q;
        push      = imem_ack && !redirect && (issue || (state_q == WAIT));
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (push) begin
            pc_d = pc_q + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= imem_addr;
        end
    end

    assign pop        = instr_valid && instr_ready;
    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .n_rst       (n_rst),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .full_o      (fifo_full)
    );

    assign instr_valid = n_rst && (fifo_count != '0);
    assign instr       = head_entry.instr;
    assign instr_pc    = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (instr_valid && instr_ready) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (imem_req && !imem_ack) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a random-latency memory model
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int lat_mode = 0;

    fetch_entry_t exp_q[$];
    logic [31:0]  exp_next;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference: after reset or redirect, decode sees consecutive words from the target.
    task automatic expect_stream(input logic [31:0] start);
        exp_q.delete();
        exp_next = start;
    endtask

    // Memory model: latches each new request, checks it is held, acks after a latency.
    logic        out_v = 1'b0;
    logic [31:0] out_addr;
    int          wait_cnt;

    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (!n_rst) begin
            out_v = 1'b0;
        end else begin
            if (out_v) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, out_addr);
            end else if (imem_req) begin
                out_v    = 1'b1;
                out_addr = imem_addr;
                wait_cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end
            if (out_v) begin
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(out_addr);
                    out_v      = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Scoreboard monitor: every decode transfer pops the next expected entry.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (n_rst && instr_valid && instr_ready && !redirect) begin
            while (exp_q.size() < 4) begin
                exp_q.push_back('{pc: exp_next, instr: mem_word(exp_next)});
                exp_next = exp_next + 32'd4;
            end
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.instr);
            n_xfer++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst    = 1'b0;
        redirect = 1'b0;
        step();
        step();
        samp();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        n_rst = 1'b1;
        expect_stream(RESET_PC);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Back-to-back fetch with same-cycle ack and decode draining
        lat_mode = 0;
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("bb_req", {31'd0, imem_req}, 32'd1);
            chk("bb_addr", imem_addr, 32'(4 * i));
            if (i > 0) begin
                chk("bb_valid", {31'd0, instr_valid}, 32'd1);
                chk("bb_pc", instr_pc, 32'(4 * (i - 1)));
            end
            step();
        end

        // Decode stalled: buffer fills, request drops, resumes at 0x8
        instr_ready = 1'b0;
        do_reset();
        step();
        step();
        samp();
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_valid", {31'd0, instr_valid}, 32'd1);
        chk("full_head", instr_pc, 32'h0);
        step();
        samp();
        chk("full_req2", {31'd0, imem_req}, 32'd0);
        step();
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            samp();
            if (imem_req) break;
            step();
        end
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        chk("resume_addr", imem_addr, 32'h8);
        step();

        // Slow memory: request held four cycles
        lat_mode = 3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("slow_req", {31'd0, imem_req}, 32'd1);
            chk("slow_addr", imem_addr, 32'h0);
            if (i == 1) chk("slow_state", 32'(dut.state_q), 32'(WAIT));
`ifdef FETCH_PERF_CNT_EN
            if (i == 3) chk("perf_stall", perf_stall, 32'd3);
`endif
            step();
        end

        // Redirect while waiting: old data dropped, refetch from aligned target
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1002;
        expect_stream(32'h0000_1000);
        step();
        redirect = 1'b0;
        samp();
        chk("drop_state", 32'(dut.state_q), 32'(DROP));
        chk("drop_addr", imem_addr, 32'h0);
        chk("drop_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            samp();
            if (imem_addr != 32'h0) break;
        end
        chk("drop_next_addr", imem_addr, 32'h0000_1000);
        chk("drop_empty", {31'd0, instr_valid}, 32'd0);
        step();

        // Redirect coincident with ack and decode ready
        lat_mode = 0;
        instr_ready = 1'b0;
        do_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        instr_ready = 1'b1;
        expect_stream(32'h0000_0200);
        step();
        redirect = 1'b0;
        samp();
        chk("coinc_valid", {31'd0, instr_valid}, 32'd0);
        chk("coinc_addr", imem_addr, 32'h0000_0200);
        step();

        // PC wraps past the top of the address space
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        expect_stream(32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        samp();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        samp();
        chk("wrap_addr1", imem_addr, 32'h0);
        step();

        // Reset while a request is outstanding
        lat_mode = 3;
        do_reset();
        step();
        n_rst = 1'b0;
        samp();
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        step();
        samp();
        chk("midrst_req2", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        step();
        n_rst = 1'b1;
        expect_stream(RESET_PC);
        samp();
        chk("midrst_addr", imem_addr, RESET_PC);
        chk("midrst_req3", {31'd0, imem_req}, 32'd1);

        // Random traffic against the stream model
        lat_mode = -1;
        n_xfer = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            redirect    = 1'b0;
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
                expect_stream(redirect_pc & ~32'h3);
            end
        end
        step();
        redirect = 1'b0;
        chk("enough_xfers", {31'd0, n_xfer > 500}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC fetched first after reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries; only 2 is supported.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  instruction memory request.
REQ-006 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_ack  input  1  instruction memory response valid; may assert in the same cycle as imem_req or later.
REQ-008 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 SHALL have port redirect  input  1  branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port instr_valid  output  1  buffer head valid toward decode.
REQ-012 SHALL have port instr  output  32  buffer head instruction.
REQ-013 SHALL have port instr_pc  output  32  buffer head PC.
REQ-014 SHALL have port instr_ready  input  1  decode accepts head; a transfer occurs when instr_valid & instr_ready.

Function
REQ-015 SHALL implement FSM states FETCH, WAIT, DROP.
REQ-016 FETCH: SHALL assert imem_req with imem_addr=pc when buffer count<2; else SHALL hold imem_req=0.
REQ-017 SHALL hold imem_req=1 and imem_addr stable from issue until imem_ack; FETCH->WAIT on issue without ack; WAIT->FETCH on ack.
REQ-018 On accepted ack (FETCH or WAIT, no redirect) SHALL push {pc, imem_rdata} and set pc<=pc+4, modulo 2^32 wrap.
REQ-019 With same-cycle ack, SHALL sustain 1 instruction/cycle while decode drains every cycle.
REQ-020 instr_valid SHALL equal count!=0; instr/instr_pc SHALL show the oldest entry; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 On redirect SHALL flush the buffer (instr_valid=0 next cycle) and set pc<=redirect_pc with bits[1:0] forced to 0.
REQ-022 Redirect while a request is outstanding without ack SHALL go to DROP; DROP SHALL keep the old request asserted until ack, discard that data, then return to FETCH.
REQ-023 Redirect coincident with ack SHALL discard the ack data and go to FETCH; redirect SHALL take priority over ack, push and pop.
REQ-024 Redirect in DROP SHALL update pc again and remain in DROP.

Reset
REQ-025 While n_rst=0 at a clock edge: state<=FETCH, pc<=RESET_PC, count<=0, imem_req=0, instr_valid=0.
REQ-026 First imem_req SHALL assert in the first cycle with n_rst=1, addressing RESET_PC.
REQ-027 Reset mid-request SHALL abandon the request; any subsequent stale ack SHALL NOT be required to be handled.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs perf_fetched (32, counts decode transfers) and perf_stall (32, counts cycles with imem_req&!imem_ack), both reset to 0 and wrapping.
REQ-029 Macro undefined: those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-030 Package fetch_pkg SHALL hold fetch_state_t enum (FETCH, WAIT, DROP), fetch_entry_t struct {pc[31:0], instr[31:0]}, and the constant INSTR_BYTES=4.
REQ-031 Buffer SHALL be sub-module fetch_fifo (2-entry, push/pop/flush, count output).

Verification
REQ-032 Reset release, ack same cycle, rdata=32'h00000013, instr_ready=1 -> addrs 0x0,0x4,0x8 on consecutive cycles; instr_pc 0x0 with instr_valid one cycle after first ack.
REQ-033 instr_ready=0, single-cycle acks -> exactly 2 entries buffered, imem_req drops to 0; raising instr_ready resumes fetch at 0x8.
REQ-034 Ack delayed 3 cycles -> imem_req and imem_addr=0x0 stable for all 4 cycles; WAIT entered; perf_stall=3 with FETCH_PERF_CNT_EN.
REQ-035 Redirect to 0x1002 during WAIT -> DROP; old ack data not pushed; next imem_addr=0x1000; buffer empty.
REQ-036 Redirect to 0x200 in the same cycle as ack and instr_ready -> no push, count 0, next imem_addr=0x200.
REQ-037 pc=0xFFFFFFFC acked -> next imem_addr=0x00000000; n_rst=0 mid-WAIT -> imem_req=0, instr_valid=0, imem_addr=RESET_PC after release.
